key_expand_ctrl: RTL and testbench
==================================

KEY_EXPAND_CTRL -- requirements
Module: key_expand_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning the number of round keys generated after the cipher key.
REQ-002 SHALL have parameter KS_TIMEOUT, default 15, meaning the maximum WAIT cycles allowed for each key-schedule round.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port key_load_in, input, 1 bit: single-cycle request to expand cipher_key_in.
REQ-006 SHALL have port cipher_key_in, input, 128 bits: cipher key, sampled when the load is accepted.
REQ-007 SHALL have ports ks_start_out (output, 1), ks_round_out (output, 4) and ks_last_key_out (output, 128): drive the key-schedule core's start, round and last-key inputs.
REQ-008 SHALL have ports ks_ready_in (input, 1) and ks_new_key_in (input, 128): the key-schedule core's ready and new-key outputs.
REQ-009 SHALL have ports rd_round_in (input, 4) and rd_key_out (output, 128): round-key read port.
REQ-010 SHALL have ports busy_out, keys_valid_out and error_out (outputs, 1 bit each): status.

Function
REQ-011 SHALL implement FSM states IDLE, START, WAIT, STORE.
- IDLE -> START on key_load_in.
- START -> WAIT.
- WAIT -> STORE on ks_ready_in.
- STORE -> START if round < NUM_ROUNDS, else -> IDLE.
REQ-012 On load acceptance (IDLE and key_load_in), SHALL write cipher_key_in to key slot 0, set round=1, clear keys_valid_out and clear error_out.
REQ-013 SHALL assert ks_start_out for exactly one cycle per round, in START.
REQ-014 SHALL hold ks_round_out=round and ks_last_key_out=slot[round-1] stable from START through STORE; the core samples them combinationally.
REQ-015 In STORE, SHALL write the value of ks_new_key_in captured at ks_ready_in into slot[round], then increment round.
REQ-016 SHALL set keys_valid_out=1 on the STORE of round NUM_ROUNDS; it stays set until the next accepted load.
REQ-017 SHALL assert busy_out=1 in every state except IDLE.
REQ-018 SHALL ignore key_load_in while busy_out=1; no queuing.
REQ-019 SHALL register rd_key_out with 1-cycle latency: rd_key_out = slot[rd_round_in] when keys_valid_out=1 and rd_round_in<=NUM_ROUNDS, else 128'h0.
REQ-020 Timeout: when the WAIT counter reaches KS_TIMEOUT without ks_ready_in, SHALL set error_out, go to IDLE and leave keys_valid_out=0.
REQ-021 error_out SHALL be sticky until the next accepted load.
REQ-022 A ks_ready_in outside WAIT SHALL be ignored.
REQ-023 A ks_ready_in in the same cycle as timeout expiry SHALL win: go to STORE, no error.

Reset
REQ-024 While rst=0, SHALL force state=IDLE, round=0, counter=0 and all outputs to 0, including rd_key_out.
REQ-025 Key slots SHALL NOT be reset; keys_valid_out=0 masks them.
REQ-026 Reset assertion mid-expansion SHALL abort the expansion; keys_valid_out=0 afterwards.

Configuration
REQ-027 With KEY_EXPAND_DECRYPT_EN defined, SHALL add input rd_decrypt_in (1 bit); when rd_decrypt_in=1, the read address is NUM_ROUNDS-rd_round_in, with the same range check applied to rd_round_in.
REQ-028 Without KEY_EXPAND_DECRYPT_EN, the rd_decrypt_in port SHALL NOT exist and reads SHALL be forward-only.

Structure
REQ-029 Shared package aes_pkg SHALL hold the FSM state encoding, the AES_KEY_W=128 constant and the NUM_ROUNDS default.
REQ-030 Key storage SHALL be a sub-module round_key_rf: 11x128, 1 write port and 1 registered read port.

Verification
REQ-031 Load 2b7e151628aed2a6abf7158809cf4f3c with a behavioural core model -> slot1 a0fafe1788542cb123a339392a6c7605, slot10 d014f9a8c9ee2589e13f0cc8b6630ca6, keys_valid_out=1, exactly 10 ks_start_out pulses.
REQ-032 rd_round_in=11, or a read before keys_valid_out -> rd_key_out=0 one cycle later.
REQ-033 Core model withholds ks_ready_in in round 4 -> error_out=1 after 15 WAIT cycles, then IDLE, keys_valid_out=0; the next load clears error_out.
REQ-034 key_load_in pulsed during round 3 -> ignored, expansion completes with the original key.
REQ-035 rst=0 in round 6, then a new load -> correct keys for the new key.
REQ-036 With KEY_EXPAND_DECRYPT_EN defined: rd_decrypt_in=1, rd_round_in=0 -> d014f9a8c9ee2589e13f0cc8b6630ca6.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-expansion definitions: key width, round count default and FSM encoding.
package aes_pkg;

   localparam int unsigned AES_KEY_W      = 128;
   localparam int unsigned NUM_ROUNDS_DEF = 10;
   localparam int unsigned ROUND_W        = 4;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StWait,
      StStore
   } ks_state_e;

endpackage

// File: rtl/key_expand_ctrl_if.sv
// Handshake between the expansion controller (master) and the key-schedule core (slave).
interface key_expand_ctrl_if;
   import aes_pkg::*;

   logic                 ks_start_out;
   logic [ROUND_W-1:0]   ks_round_out;
   logic [AES_KEY_W-1:0] ks_last_key_out;
   logic                 ks_ready_in;
   logic [AES_KEY_W-1:0] ks_new_key_in;

   modport master (
      output ks_start_out,
      output ks_round_out,
      output ks_last_key_out,
      input  ks_ready_in,
      input  ks_new_key_in
   );

   modport slave (
      input  ks_start_out,
      input  ks_round_out,
      input  ks_last_key_out,
      output ks_ready_in,
      output ks_new_key_in
   );

endinterface

// File: rtl/round_key_rf.sv
// Round-key storage: one write port, one registered read port that returns zero when not enabled.
module round_key_rf
   import aes_pkg::*;
#(
   parameter int unsigned DEPTH = NUM_ROUNDS_DEF + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [ROUND_W-1:0]   waddr,
   input  logic [AES_KEY_W-1:0] wdata,
   input  logic                 re,
   input  logic [ROUND_W-1:0]   raddr,
   output logic [AES_KEY_W-1:0] rdata
);

   logic [AES_KEY_W-1:0] mem [DEPTH];

   // Key slots carry no reset; validity is tracked by the controller.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read, forced to zero when the read is masked.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end else begin
         rdata <= '0;
      end
   end

endmodule

// File: rtl/key_expand_ctrl.sv
// AES-128 key-expansion controller: sequences an external key-schedule core round by round,
// stores every round key and serves a registered read port.
// Optional macro KEY_EXPAND_DECRYPT_EN adds rd_decrypt_in for reverse-order reads.
module key_expand_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF,
   parameter int unsigned KS_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_load_in,
   input  logic [AES_KEY_W-1:0]  cipher_key_in,
   key_expand_ctrl_if.master     ks,
   input  logic [ROUND_W-1:0]    rd_round_in,
`ifdef KEY_EXPAND_DECRYPT_EN
   input  logic                  rd_decrypt_in,
`endif
   output logic [AES_KEY_W-1:0]  rd_key_out,
   output logic                  busy_out,
   output logic                  keys_valid_out,
   output logic                  error_out
);

   localparam int unsigned        CNT_W      = $clog2(KS_TIMEOUT + 1);
   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(KS_TIMEOUT - 1);

   ks_state_e            state_q;
   logic [ROUND_W-1:0]   round_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 start_q;
   logic                 busy_q;
   logic                 valid_q;
   logic                 error_q;
   logic [AES_KEY_W-1:0] last_key_q;
   logic [AES_KEY_W-1:0] new_key_q;

   logic                 rf_we;
   logic [ROUND_W-1:0]   rf_waddr;
   logic [AES_KEY_W-1:0] rf_wdata;
   logic                 rf_re;
   logic [ROUND_W-1:0]   rf_raddr;
   logic                 rd_dec;

   // Single FSM; all outputs are registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         round_q    <= '0;
         cnt_q      <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         error_q    <= 1'b0;
         last_key_q <= '0;
         new_key_q  <= '0;
      end else begin
         start_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (key_load_in) begin
                  state_q    <= StStart;
                  round_q    <= 4'd1;
                  start_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  valid_q    <= 1'b0;
                  error_q    <= 1'b0;
                  last_key_q <= cipher_key_in;
               end
            end
            StStart: begin
               state_q <= StWait;
               cnt_q   <= '0;
            end
            StWait: begin
               // Ready has priority over an expiring timeout.
               if (ks.ks_ready_in) begin
                  new_key_q <= ks.ks_new_key_in;
                  state_q   <= StStore;
               end else if (cnt_q == CNT_LAST) begin
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StStore: begin
               round_q    <= round_q + 4'd1;
               last_key_q <= new_key_q;
               if (round_q == LAST_ROUND) begin
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  start_q <= 1'b1;
                  state_q <= StStart;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Slot 0 takes the cipher key on load; later slots take the captured core result.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = cipher_key_in;
      if (state_q == StIdle && key_load_in) begin
         rf_we = 1'b1;
      end else if (state_q == StStore) begin
         rf_we    = 1'b1;
         rf_waddr = round_q;
         rf_wdata = new_key_q;
      end
   end

`ifdef KEY_EXPAND_DECRYPT_EN
   assign rd_dec = rd_decrypt_in;
`else
   assign rd_dec = 1'b0;
`endif

   // Range check always applies to the requested round, not the mapped address.
   always_comb begin
      rf_re    = valid_q && (rd_round_in <= LAST_ROUND);
      rf_raddr = rd_dec ? (LAST_ROUND - rd_round_in) : rd_round_in;
   end

   round_key_rf #(
      .DEPTH(NUM_ROUNDS + 1)
   ) u_rf (
      .clk  (clk),
      .rst  (rst),
      .we   (rf_we),
      .waddr(rf_waddr),
      .wdata(rf_wdata),
      .re   (rf_re),
      .raddr(rf_raddr),
      .rdata(rd_key_out)
   );

   assign ks.ks_start_out    = start_q;
   assign ks.ks_round_out    = round_q;
   assign ks.ks_last_key_out = last_key_q;
   assign busy_out           = busy_q;
   assign keys_valid_out     = valid_q;
   assign error_out          = error_q;

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Bench for key_expand_ctrl: AES-128 key-schedule core model plus a read-data scoreboard.
module tb_key_expand_ctrl;
   import aes_pkg::*;

   localparam int NR = 10;
   localparam int TO = 15;
   localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1R1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K1RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K3   = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         key_load_in = 1'b0;
   logic [127:0] cipher_key_in = '0;
   logic [3:0]   rd_round_in = '0;
`ifdef KEY_EXPAND_DECRYPT_EN
   logic         rd_decrypt_in = 1'b0;
`endif
   logic [127:0] rd_key_out;
   logic         busy_out, keys_valid_out, error_out;

   key_expand_ctrl_if ks_if ();

   key_expand_ctrl #(
      .NUM_ROUNDS(NR),
      .KS_TIMEOUT(TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .key_load_in   (key_load_in),
      .cipher_key_in (cipher_key_in),
      .ks            (ks_if),
      .rd_round_in   (rd_round_in),
`ifdef KEY_EXPAND_DECRYPT_EN
      .rd_decrypt_in (rd_decrypt_in),
`endif
      .rd_key_out    (rd_key_out),
      .busy_out      (busy_out),
      .keys_valid_out(keys_valid_out),
      .error_out     (error_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cycles = 0;
   int err_edges = -1;
   int withhold_round = 0;
   int tie_round = 0;
   logic [127:0] sched [0:NR];

   typedef struct {
      int           cyc;
      logic [127:0] exp;
      string        name;
   } rd_exp_t;
   rd_exp_t sb [$];

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_b(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_i(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- AES-128 key schedule reference ----------------
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(logic [7:0] x);
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
             {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] ks_step(logic [127:0] k, logic [3:0] r);
      logic [31:0] w3, rot, t, n0, n1, n2, n3;
      logic [7:0]  rc = 8'h01;
      for (int i = 1; i < int'(r); i++) rc = gmul(rc, 8'h02);
      w3  = k[31:0];
      rot = {w3[23:0], w3[31:24]};
      t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
      n0  = k[127:96] ^ t;
      n1  = k[95:64] ^ n0;
      n2  = k[63:32] ^ n1;
      n3  = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   task automatic compute_sched(logic [127:0] key);
      sched[0] = key;
      for (int i = 1; i <= NR; i++) sched[i] = ks_step(sched[i-1], 4'(i));
   endtask

   // ---------------- key-schedule core model ----------------
   initial begin
      logic [3:0]   r;
      logic [127:0] last;
      int           d;
      int           exp_round;
      exp_round = 1;
      ks_if.ks_ready_in   = 1'b0;
      ks_if.ks_new_key_in = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!busy_out) exp_round = 1;
         if (ks_if.ks_start_out === 1'b1) begin
            r    = ks_if.ks_round_out;
            last = ks_if.ks_last_key_out;
            check_i("ks_round_seq", int'(r), exp_round);
            exp_round++;
            if (r >= 4'd1 && r <= 4'(NR)) check($sformatf("ks_last_key_r%0d", r), last, sched[r-4'd1]);
            if (int'(r) == withhold_round) begin
               // Edges after the START cycle until error appears.
               for (int k = 1; k <= 40; k++) begin
                  @(posedge clk);
                  #1;
                  if (error_out) begin
                     err_edges = k;
                     break;
                  end
               end
            end else begin
               d = (int'(r) == tie_round) ? TO : 2;
               repeat (d) @(posedge clk);
               #1;
               ks_if.ks_ready_in   = 1'b1;
               ks_if.ks_new_key_in = ks_step(last, r);
               @(posedge clk);
               #1;
               ks_if.ks_ready_in   = 1'b0;
               ks_if.ks_new_key_in = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
            end
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (ks_if.ks_start_out === 1'b1) start_cycles <= start_cycles + 1;

   // Read-data monitor: compare each scoreboard entry in the cycle its data is due.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         rd_exp_t e;
         e = sb.pop_front();
         check(e.name, rd_key_out, e.exp);
      end
   end

   task automatic issue_read(logic [3:0] r, logic [127:0] exp, string name);
      @(negedge clk);
      rd_round_in = r;
`ifdef KEY_EXPAND_DECRYPT_EN
      rd_decrypt_in = 1'b0;
`endif
      sb.push_back('{cyc + 1, exp, name});
   endtask

`ifdef KEY_EXPAND_DECRYPT_EN
   task automatic issue_read_dec(logic [3:0] r, logic [127:0] exp, string name);
      @(negedge clk);
      rd_round_in   = r;
      rd_decrypt_in = 1'b1;
      sb.push_back('{cyc + 1, exp, name});
   endtask
`endif

   task automatic drain(string name);
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_i(name, sb.size(), 0);
   endtask

   task automatic load_key(logic [127:0] k);
      @(negedge clk);
      cipher_key_in = k;
      key_load_in   = 1'b1;
      @(negedge clk);
      key_load_in   = 1'b0;
      cipher_key_in = ~k;
   endtask

   task automatic wait_not_busy(string name);
      int n = 0;
      while (busy_out && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_b(name, busy_out, 1'b0);
   endtask

   task automatic wait_round_start(logic [3:0] r, string name);
      int n = 0;
      while (!(ks_if.ks_start_out && ks_if.ks_round_out == r) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check(name, {123'b0, ks_if.ks_start_out, ks_if.ks_round_out}, {123'b0, 1'b1, r});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int s0;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check_b("rst_busy", busy_out, 1'b0);
      check_b("rst_valid", keys_valid_out, 1'b0);
      check_b("rst_error", error_out, 1'b0);
      check_b("rst_start", ks_if.ks_start_out, 1'b0);
      check("rst_round", {124'b0, ks_if.ks_round_out}, 128'd0);
      check("rst_last_key", ks_if.ks_last_key_out, 128'd0);
      check("rst_rd_key", rd_key_out, 128'd0);
      @(negedge clk);
      rst = 1'b1;

      issue_read(4'd0, 128'd0, "rd_before_valid");
      drain("drain_pre");

      // Full expansion of the reference key; round 2 answers exactly at timeout expiry.
      compute_sched(K1);
      tie_round = 2;
      s0 = start_cycles;
      load_key(K1);
      check_b("load_busy", busy_out, 1'b1);
      check_b("load_valid_clr", keys_valid_out, 1'b0);
      wait_not_busy("k1_done");
      tie_round = 0;
      check_b("k1_valid", keys_valid_out, 1'b1);
      check_b("k1_no_error", error_out, 1'b0);
      check_i("k1_start_pulses", start_cycles - s0, NR);
      issue_read(4'd1, K1R1, "k1_slot1");
      issue_read(4'd10, K1RA, "k1_slot10");
      issue_read(4'd0, K1, "k1_slot0");
      issue_read(4'd5, sched[5], "k1_slot5");
      issue_read(4'd11, 128'd0, "rd_round11");
      issue_read(4'd15, 128'd0, "rd_round15");
`ifdef KEY_EXPAND_DECRYPT_EN
      issue_read_dec(4'd0, K1RA, "dec_round0");
      issue_read_dec(4'd10, K1, "dec_round10");
      issue_read_dec(4'd11, 128'd0, "dec_round11");
`endif
      drain("drain_k1");

      // A second load during round 3 must be ignored.
      compute_sched(K2);
      s0 = start_cycles;
      load_key(K2);
      wait_round_start(4'd3, "k2_round3");
      issue_read(4'd1, 128'd0, "rd_while_busy");
      load_key(K1);
      wait_not_busy("k2_done");
      check_b("k2_valid", keys_valid_out, 1'b1);
      check_i("k2_start_pulses", start_cycles - s0, NR);
      issue_read(4'd1, sched[1], "k2_slot1");
      issue_read(4'd10, sched[10], "k2_slot10");
      drain("drain_k2");

      // Core withholds ready in round 4.
      compute_sched(K1);
      withhold_round = 4;
      load_key(K1);
      begin
         int n = 0;
         while (!error_out && n < 500) begin
            @(negedge clk);
            n++;
         end
      end
      withhold_round = 0;
      check_b("to_error", error_out, 1'b1);
      check_i("to_edges", err_edges, TO + 1);
      check_b("to_idle", busy_out, 1'b0);
      check_b("to_valid", keys_valid_out, 1'b0);
      repeat (5) @(negedge clk);
      check_b("to_error_sticky", error_out, 1'b1);
      issue_read(4'd1, 128'd0, "to_rd_masked");
      drain("drain_to");

      // Next load clears the error.
      compute_sched(K3);
      load_key(K3);
      check_b("reload_err_clr", error_out, 1'b0);
      wait_not_busy("k3_done");
      check_b("k3_valid", keys_valid_out, 1'b1);
      issue_read(4'd10, sched[10], "k3_slot10");
      drain("drain_k3");

      // Reset during round 6 aborts; a fresh load afterwards expands correctly.
      compute_sched(K2);
      load_key(K2);
      wait_round_start(4'd6, "k2b_round6");
      rst = 1'b0;
      #1;
      check_b("arst_busy", busy_out, 1'b0);
      check_b("arst_start", ks_if.ks_start_out, 1'b0);
      check("arst_rd_key", rd_key_out, 128'd0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      check_b("arst_valid", keys_valid_out, 1'b0);
      issue_read(4'd1, 128'd0, "arst_rd_masked");
      drain("drain_arst");
      compute_sched(128'd0);
      load_key(128'd0);
      wait_not_busy("k0_done");
      check_b("k0_valid", keys_valid_out, 1'b1);
      issue_read(4'd0, 128'd0, "k0_slot0");
      issue_read(4'd1, sched[1], "k0_slot1");
      issue_read(4'd10, sched[10], "k0_slot10");
      drain("drain_k0");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
